// File: rtl/control_sequencer.sv
// Five-step microcode sequencer for an 8-bit accumulator CPU.
// Decodes the datapath control word from the T-state and the IR opcode nibble.
module control_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       flag_zero,
  input  logic       flag_carry,
  output logic [2:0] step,
  output logic       pc_enable,
  output logic       pc_load,
  output logic       pc_oe,
  output logic       mar_load,
  output logic       ram_oe,
  output logic       ram_we,
  output logic       ir_load,
  output logic       ir_oe,
  output logic       a_load,
  output logic       a_oe,
  output logic       b_load,
  output logic       alu_oe,
  output logic       alu_sub,
  output logic       flags_load,
  output logic       out_load,
  output logic       halt
);

  localparam int unsigned STEP_W = 3;

  typedef enum logic [STEP_W-1:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    HALT = 3'd5
  } state_t;

  typedef struct packed {
    logic pc_enable;
    logic pc_load;
    logic pc_oe;
    logic mar_load;
    logic ram_oe;
    logic ram_we;
    logic ir_load;
    logic ir_oe;
    logic a_load;
    logic a_oe;
    logic b_load;
    logic alu_oe;
    logic alu_sub;
    logic flags_load;
    logic out_load;
    logic halt;
  } ctrl_t;

  state_t state;
  state_t state_next;
  ctrl_t  cw;
  ctrl_t  ctrl;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= T0;
    else       state <= state_next;
  end

  // Next-state and control-word decode
  always_comb begin
    state_next = state;
    cw         = '0;
    case (state)
      T0: begin
        cw.pc_oe    = 1'b1;
        cw.mar_load = 1'b1;
        state_next  = T1;
      end
      T1: begin
        cw.ram_oe    = 1'b1;
        cw.ir_load   = 1'b1;
        cw.pc_enable = 1'b1;
        state_next   = T2;
      end
      T2: begin
        state_next = T0;
        case (opcode)
          4'h1, 4'h2, 4'h3, 4'h4: begin
            cw.ir_oe    = 1'b1;
            cw.mar_load = 1'b1;
            state_next  = T3;
          end
          4'h5: begin
            cw.ir_oe  = 1'b1;
            cw.a_load = 1'b1;
          end
          4'h6: begin
            cw.ir_oe   = 1'b1;
            cw.pc_load = 1'b1;
          end
          4'h7: begin
            cw.ir_oe   = flag_carry;
            cw.pc_load = flag_carry;
          end
          4'h8: begin
            cw.ir_oe   = flag_zero;
            cw.pc_load = flag_zero;
          end
          4'hE: begin
            cw.a_oe     = 1'b1;
            cw.out_load = 1'b1;
          end
          4'hF: state_next = HALT;
          default: ;
        endcase
      end
      T3: begin
        state_next = T0;
        case (opcode)
          4'h1: begin
            cw.ram_oe = 1'b1;
            cw.a_load = 1'b1;
          end
          4'h2, 4'h3: begin
            cw.ram_oe  = 1'b1;
            cw.b_load  = 1'b1;
            state_next = T4;
          end
          4'h4: begin
            cw.a_oe   = 1'b1;
            cw.ram_we = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        state_next = T0;
        if (opcode == 4'h2 || opcode == 4'h3) begin
          cw.alu_oe     = 1'b1;
          cw.a_load     = 1'b1;
          cw.flags_load = 1'b1;
          cw.alu_sub    = (opcode == 4'h3);
        end
      end
      HALT: begin
        cw.halt    = 1'b1;
        state_next = HALT;
      end
      default: state_next = T0;
    endcase
  end

  // Reset masks the whole control word within the cycle it is asserted
  assign ctrl = reset ? '0 : cw;
  assign step = STEP_W'(state);

  assign pc_enable  = ctrl.pc_enable;
  assign pc_load    = ctrl.pc_load;
  assign pc_oe      = ctrl.pc_oe;
  assign mar_load   = ctrl.mar_load;
  assign ram_oe     = ctrl.ram_oe;
  assign ram_we     = ctrl.ram_we;
  assign ir_load    = ctrl.ir_load;
  assign ir_oe      = ctrl.ir_oe;
  assign a_load     = ctrl.a_load;
  assign a_oe       = ctrl.a_oe;
  assign b_load     = ctrl.b_load;
  assign alu_oe     = ctrl.alu_oe;
  assign alu_sub    = ctrl.alu_sub;
  assign flags_load = ctrl.flags_load;
  assign out_load   = ctrl.out_load;
  assign halt       = ctrl.halt;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer: per-instruction step/control-word
// tables plus a per-cycle bus-exclusivity monitor.
module tb_control_sequencer;

  localparam logic [15:0] M_PC_EN   = 16'h8000;
  localparam logic [15:0] M_PC_LOAD = 16'h4000;
  localparam logic [15:0] M_PC_OE   = 16'h2000;
  localparam logic [15:0] M_MAR     = 16'h1000;
  localparam logic [15:0] M_RAM_OE  = 16'h0800;
  localparam logic [15:0] M_RAM_WE  = 16'h0400;
  localparam logic [15:0] M_IR_LOAD = 16'h0200;
  localparam logic [15:0] M_IR_OE   = 16'h0100;
  localparam logic [15:0] M_A_LOAD  = 16'h0080;
  localparam logic [15:0] M_A_OE    = 16'h0040;
  localparam logic [15:0] M_B_LOAD  = 16'h0020;
  localparam logic [15:0] M_ALU_OE  = 16'h0010;
  localparam logic [15:0] M_ALU_SUB = 16'h0008;
  localparam logic [15:0] M_FLAGS   = 16'h0004;
  localparam logic [15:0] M_OUT     = 16'h0002;
  localparam logic [15:0] M_HALT    = 16'h0001;

  localparam logic [15:0] FETCH0 = M_PC_OE | M_MAR;
  localparam logic [15:0] FETCH1 = M_RAM_OE | M_IR_LOAD | M_PC_EN;

  logic       clk;
  logic       reset;
  logic [3:0] opcode;
  logic       flag_zero;
  logic       flag_carry;
  logic [2:0] step;
  logic pc_enable, pc_load, pc_oe, mar_load, ram_oe, ram_we, ir_load, ir_oe;
  logic a_load, a_oe, b_load, alu_oe, alu_sub, flags_load, out_load, halt;
  logic [15:0] cw_obs;

  int checks = 0;
  int passes = 0;

  control_sequencer dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .step(step),
    .pc_enable(pc_enable), .pc_load(pc_load), .pc_oe(pc_oe),
    .mar_load(mar_load), .ram_oe(ram_oe), .ram_we(ram_we),
    .ir_load(ir_load), .ir_oe(ir_oe), .a_load(a_load), .a_oe(a_oe),
    .b_load(b_load), .alu_oe(alu_oe), .alu_sub(alu_sub),
    .flags_load(flags_load), .out_load(out_load), .halt(halt)
  );

  assign cw_obs = {pc_enable, pc_load, pc_oe, mar_load, ram_oe, ram_we, ir_load, ir_oe,
                   a_load, a_oe, b_load, alu_oe, alu_sub, flags_load, out_load, halt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus and RAM-direction invariants, every cycle
  always @(negedge clk) begin
    checks = checks + 1;
    if ($countones({pc_oe, ram_oe, ir_oe, a_oe, alu_oe}) > 1)
      $display("FAIL bus_exclusive t=%0t: drivers=%b required at most one", $time,
               {pc_oe, ram_oe, ir_oe, a_oe, alu_oe});
    else passes = passes + 1;
    checks = checks + 1;
    if (ram_we && ram_oe)
      $display("FAIL ram_we_oe t=%0t: ram_we=%b ram_oe=%b required not both", $time,
               ram_we, ram_oe);
    else passes = passes + 1;
  end

  // Runs one instruction from T0; opcode and flags are scrambled during fetch
  task automatic run_instr(input string name, input logic [3:0] op, input logic fz,
                           input logic fc, input int len, input logic [15:0] e2,
                           input logic [15:0] e3, input logic [15:0] e4);
    logic [15:0] exp_cw;
    for (int i = 0; i < len; i++) begin
      if (i < 2) begin
        opcode = ~op; flag_zero = ~fz; flag_carry = ~fc;
      end else begin
        opcode = op; flag_zero = fz; flag_carry = fc;
      end
      case (i)
        0:       exp_cw = FETCH0;
        1:       exp_cw = FETCH1;
        2:       exp_cw = e2;
        3:       exp_cw = e3;
        default: exp_cw = e4;
      endcase
      @(negedge clk);
      checks = checks + 1;
      if (step !== 3'(i))
        $display("FAIL %s step cycle %0d: got %0d want %0d", name, i, step, i);
      else passes = passes + 1;
      checks = checks + 1;
      if (cw_obs !== exp_cw)
        $display("FAIL %s cw cycle %0d: got %h want %h", name, i, cw_obs, exp_cw);
      else passes = passes + 1;
      @(posedge clk); #1;
    end
    checks = checks + 1;
    if (step !== 3'd0)
      $display("FAIL %s return_t0: got step %0d want 0", name, step);
    else passes = passes + 1;
  endtask

  task automatic test_reset();
    reset = 1'b1; opcode = 4'h0; flag_zero = 1'b0; flag_carry = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if (cw_obs !== 16'h0000) $display("FAIL reset_cw: got %h want 0000", cw_obs);
    else passes = passes + 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if (step !== 3'd0 || cw_obs !== FETCH0)
      $display("FAIL reset_c0: got step %0d cw %h want 0 %h", step, cw_obs, FETCH0);
    else passes = passes + 1;
    @(posedge clk); #1;
    @(negedge clk);
    checks = checks + 1;
    if (step !== 3'd1 || cw_obs !== FETCH1)
      $display("FAIL reset_c1: got step %0d cw %h want 1 %h", step, cw_obs, FETCH1);
    else passes = passes + 1;
    @(posedge clk); #1;
    @(negedge clk);
    checks = checks + 1;
    if (step !== 3'd2 || cw_obs !== 16'h0000)
      $display("FAIL reset_nop_t2: got step %0d cw %h want 2 0000", step, cw_obs);
    else passes = passes + 1;
    @(posedge clk); #1;
  endtask

  task automatic test_instructions();
    run_instr("nop",  4'h0, 0, 0, 3, 16'h0, 16'h0, 16'h0);
    run_instr("lda",  4'h1, 0, 0, 4, M_IR_OE | M_MAR, M_RAM_OE | M_A_LOAD, 16'h0);
    run_instr("add",  4'h2, 0, 0, 5, M_IR_OE | M_MAR, M_RAM_OE | M_B_LOAD,
              M_ALU_OE | M_A_LOAD | M_FLAGS);
    run_instr("sub",  4'h3, 1, 1, 5, M_IR_OE | M_MAR, M_RAM_OE | M_B_LOAD,
              M_ALU_OE | M_A_LOAD | M_FLAGS | M_ALU_SUB);
    run_instr("sta",  4'h4, 0, 0, 4, M_IR_OE | M_MAR, M_A_OE | M_RAM_WE, 16'h0);
    run_instr("ldi",  4'h5, 0, 0, 3, M_IR_OE | M_A_LOAD, 16'h0, 16'h0);
    run_instr("jmp",  4'h6, 0, 0, 3, M_IR_OE | M_PC_LOAD, 16'h0, 16'h0);
    run_instr("out",  4'hE, 0, 0, 3, M_A_OE | M_OUT, 16'h0, 16'h0);
    run_instr("undef_9", 4'h9, 1, 1, 3, 16'h0, 16'h0, 16'h0);
    run_instr("undef_d", 4'hD, 1, 1, 3, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic test_cond_jumps();
    run_instr("jz_nz",  4'h8, 0, 1, 3, 16'h0, 16'h0, 16'h0);
    run_instr("jz_z",   4'h8, 1, 0, 3, M_IR_OE | M_PC_LOAD, 16'h0, 16'h0);
    run_instr("jc_nc",  4'h7, 1, 0, 3, 16'h0, 16'h0, 16'h0);
    run_instr("jc_c",   4'h7, 0, 1, 3, M_IR_OE | M_PC_LOAD, 16'h0, 16'h0);
  endtask

  task automatic test_halt();
    opcode = 4'h0; flag_zero = 1'b0; flag_carry = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    opcode = 4'hF;
    @(negedge clk);
    checks = checks + 1;
    if (step !== 3'd2 || cw_obs !== 16'h0000)
      $display("FAIL hlt_t2: got step %0d cw %h want 2 0000", step, cw_obs);
    else passes = passes + 1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      opcode = 4'(i); flag_zero = i[0]; flag_carry = i[1];
      @(negedge clk);
      checks = checks + 1;
      if (step !== 3'd5 || cw_obs !== M_HALT)
        $display("FAIL halt_hold %0d: got step %0d cw %h want 5 %h", i, step, cw_obs, M_HALT);
      else passes = passes + 1;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    checks = checks + 1;
    if (cw_obs !== 16'h0000) $display("FAIL halt_reset_cw: got %h want 0000", cw_obs);
    else passes = passes + 1;
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr("post_halt_nop", 4'h0, 0, 0, 3, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic test_reset_mid_add();
    opcode = 4'h2; flag_zero = 1'b0; flag_carry = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(negedge clk);
    checks = checks + 1;
    if (cw_obs !== 16'h0000) $display("FAIL add_t3_reset_cw: got %h want 0000", cw_obs);
    else passes = passes + 1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks = checks + 1;
    if (step !== 3'd0) $display("FAIL add_t3_reset_step: got %0d want 0", step);
    else passes = passes + 1;
    run_instr("post_reset_add", 4'h2, 0, 0, 5, M_IR_OE | M_MAR, M_RAM_OE | M_B_LOAD,
              M_ALU_OE | M_A_LOAD | M_FLAGS);
  endtask

  initial begin
    test_reset();
    test_instructions();
    test_cond_jumps();
    test_halt();
    test_reset_mid_add();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
